// File: rtl/pe_types.sv
// rtl/pe_types.sv - shared PE packet layout, channel index type and autoconfig FSM states
package pe_types;

  localparam int CHANNELS_DEF = 4;

  typedef struct packed {
    logic [7:0]  addr;
    logic [23:0] data;
  } config_payload_t;

  typedef struct packed {
    logic [3:0]      op;
    config_payload_t payload;
  } packet_t;

  localparam int PKT_W_DEF = $bits(packet_t);

  typedef logic [$clog2(CHANNELS_DEF)-1:0] cfg_chan_t;

  typedef enum logic [1:0] {
    AC_IDLE,
    AC_ISSUE,
    AC_GAP,
    AC_DONE
  } ac_state_t;

  // Single place that defines how a config packet is packed; usable in parameter expressions.
  function automatic packet_t gen_config_pkt(input logic [3:0] op, input logic [7:0] addr,
                                             input logic [23:0] data);
    packet_t p;
    p.op           = op;
    p.payload.addr = addr;
    p.payload.data = data;
    return p;
  endfunction

endpackage

// File: rtl/pe_autoconfig_table.sv
// rtl/pe_autoconfig_table.sv - config table register file, one write port, one async read port
module pe_autoconfig_table #(
  parameter int DEPTH = 16,
  parameter int PKT_W = 36,
  parameter int CH_W  = 2,
  parameter int IDX_W = 4,
  parameter logic [DEPTH*PKT_W-1:0] INIT_PKTS  = '0,
  parameter logic [DEPTH*CH_W-1:0]  INIT_CHAN  = '0,
  parameter logic [DEPTH-1:0]       INIT_VALID = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [PKT_W-1:0] wr_pkt,
  input  logic [CH_W-1:0]  wr_chan,
  input  logic             wr_valid,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [PKT_W-1:0] rd_pkt,
  output logic [CH_W-1:0]  rd_chan,
  output logic             rd_valid
);

  logic [PKT_W-1:0] pkt_mem  [DEPTH];
  logic [CH_W-1:0]  chan_mem [DEPTH];
  logic [DEPTH-1:0] valid_mem;

  // Reset reloads the boot image, so a reset always restores the original table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pkt_mem[i]  <= INIT_PKTS[i*PKT_W +: PKT_W];
        chan_mem[i] <= INIT_CHAN[i*CH_W +: CH_W];
      end
      valid_mem <= INIT_VALID;
    end else if (wr_en) begin
      pkt_mem[wr_addr]   <= wr_pkt;
      chan_mem[wr_addr]  <= wr_chan;
      valid_mem[wr_addr] <= wr_valid;
    end
  end

  assign rd_pkt   = pkt_mem[rd_addr];
  assign rd_chan  = chan_mem[rd_addr];
  assign rd_valid = valid_mem[rd_addr];

endmodule

// File: rtl/pe_autoconfig_seq.sv
// rtl/pe_autoconfig_seq.sv - streams a parameter-loaded config table into per-channel PE ingress FIFOs
module pe_autoconfig_seq
  import pe_types::*;
#(
  parameter int DEPTH      = 16,
  parameter int CHANNELS   = 4,
  parameter int PKT_W      = 36,
  parameter int GAP_CYCLES = 1,
  parameter int AUTO_START = 1,
  parameter logic [DEPTH*PKT_W-1:0]            INIT_PKTS  = '0,
  parameter logic [DEPTH*$clog2(CHANNELS)-1:0] INIT_CHAN  = '0,
  parameter logic [DEPTH-1:0]                  INIT_VALID = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        cfg_wr_en,
  input  logic [$clog2(DEPTH)-1:0]    cfg_wr_addr,
  input  logic [PKT_W-1:0]            cfg_wr_pkt,
  input  logic [$clog2(CHANNELS)-1:0] cfg_wr_chan,
  input  logic                        cfg_wr_valid,
  output logic                        cfg_wr_err,
  output logic [CHANNELS-1:0]         cfg_enq,
  output logic [CHANNELS*PKT_W-1:0]   cfg_pkt,
  input  logic [CHANNELS-1:0]         cfg_full,
  output logic                        busy,
  output logic                        init_done,
  output logic [$clog2(DEPTH+1)-1:0]  sent_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CH_W  = $clog2(CHANNELS);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  ac_state_t        state;
  logic [IDX_W-1:0] idx;
  logic [GAP_W-1:0] gap_cnt;
  logic             auto_pend;

  logic [PKT_W-1:0] rd_pkt;
  logic [CH_W-1:0]  rd_chan;
  logic             rd_valid;

  logic run_active;
  logic tbl_we;
  logic issue_ok;
  logic step;

  assign run_active = (state == AC_ISSUE) || (state == AC_GAP);
  assign tbl_we     = cfg_wr_en && !run_active;

  pe_autoconfig_table #(
    .DEPTH     (DEPTH),
    .PKT_W     (PKT_W),
    .CH_W      (CH_W),
    .IDX_W     (IDX_W),
    .INIT_PKTS (INIT_PKTS),
    .INIT_CHAN (INIT_CHAN),
    .INIT_VALID(INIT_VALID)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tbl_we),
    .wr_addr (cfg_wr_addr),
    .wr_pkt  (cfg_wr_pkt),
    .wr_chan (cfg_wr_chan),
    .wr_valid(cfg_wr_valid),
    .rd_addr (idx),
    .rd_pkt  (rd_pkt),
    .rd_chan (rd_chan),
    .rd_valid(rd_valid)
  );

  // step marks the last cycle spent on the current entry: skip, gapless enqueue, or gap expiry.
  always_comb begin
    issue_ok = (state == AC_ISSUE) && rd_valid && !cfg_full[rd_chan];
    step     = ((state == AC_ISSUE) && !rd_valid)
            || (issue_ok && (GAP_CYCLES == 0))
            || ((state == AC_GAP) && (gap_cnt == '0));
  end

  always_comb begin
    cfg_enq = '0;
    cfg_pkt = '0;
    if ((state == AC_ISSUE) && rd_valid) begin
      cfg_pkt[int'(rd_chan)*PKT_W +: PKT_W] = rd_pkt;
      cfg_enq[rd_chan]                      = !cfg_full[rd_chan];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= AC_IDLE;
      idx        <= '0;
      gap_cnt    <= '0;
      sent_count <= '0;
      init_done  <= 1'b0;
      busy       <= 1'b0;
      cfg_wr_err <= 1'b0;
      auto_pend  <= (AUTO_START != 0);
    end else begin
      cfg_wr_err <= cfg_wr_en && run_active;
      auto_pend  <= 1'b0;
      if (issue_ok) begin
        sent_count <= sent_count + CNT_W'(1);
      end
      case (state)
        AC_IDLE, AC_DONE: begin
          if (start || (auto_pend && (state == AC_IDLE))) begin
            state      <= AC_ISSUE;
            idx        <= '0;
            busy       <= 1'b1;
            init_done  <= 1'b0;
            sent_count <= '0;
          end
        end
        AC_ISSUE: begin
          if (issue_ok && (GAP_CYCLES > 0)) begin
            state   <= AC_GAP;
            gap_cnt <= GAP_W'(GAP_CYCLES - 1);
          end
        end
        AC_GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: state <= AC_IDLE;
      endcase
      if (step) begin
        if (idx == LAST_IDX) begin
          state     <= AC_DONE;
          busy      <= 1'b0;
          init_done <= 1'b1;
        end else begin
          idx   <= idx + IDX_W'(1);
          state <= AC_ISSUE;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_autoconfig_seq.sv
// tb/tb_pe_autoconfig_seq.sv - self-checking bench for pe_autoconfig_seq
`timescale 1ns/1ps
module tb_pe_autoconfig_seq;
  import pe_types::*;

  localparam int DEPTH    = 5;
  localparam int CHANNELS = 4;
  localparam int PKT_W    = 36;
  localparam int GAP      = 1;
  localparam int VW       = CHANNELS * PKT_W;

  localparam logic [DEPTH*PKT_W-1:0] INIT_P = {
    gen_config_pkt(4'hA, 8'h14, 24'h444444),
    gen_config_pkt(4'hA, 8'h13, 24'h333333),
    gen_config_pkt(4'hA, 8'h12, 24'h222222),
    gen_config_pkt(4'hA, 8'h11, 24'h111111),
    gen_config_pkt(4'hA, 8'h10, 24'h000000)
  };
  localparam logic [DEPTH*2-1:0] INIT_C = {5{2'b01}};
  localparam logic [DEPTH-1:0]   INIT_V = 5'b11111;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                cfg_wr_en = 1'b0;
  logic [2:0]          cfg_wr_addr = '0;
  logic [PKT_W-1:0]    cfg_wr_pkt = '0;
  logic [1:0]          cfg_wr_chan = '0;
  logic                cfg_wr_valid = 1'b0;
  logic [CHANNELS-1:0] cfg_full = '0;
  logic                cfg_wr_err, busy, init_done;
  logic [CHANNELS-1:0] cfg_enq;
  logic [VW-1:0]       cfg_pkt;
  logic [2:0]          sent_count;

  logic                cfg_wr_err0, busy0, init_done0;
  logic [CHANNELS-1:0] cfg_enq0;
  logic [VW-1:0]       cfg_pkt0;
  logic [2:0]          sent_count0;

  int cyc;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    int          chan;
    logic [35:0] pkt;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int          addr;
    logic [35:0] pkt;
    int          chan;
    bit          valid;
    int          mode;
    int          exp_sent;
    int          exp_len;
  } vec_t;
  vec_t vecs[8];

  logic [35:0] m_pkt[DEPTH];
  cfg_chan_t   m_chan[DEPTH];
  bit          m_valid[DEPTH];

  pe_autoconfig_seq #(
    .DEPTH(DEPTH), .CHANNELS(CHANNELS), .PKT_W(PKT_W), .GAP_CYCLES(GAP), .AUTO_START(1),
    .INIT_PKTS(INIT_P), .INIT_CHAN(INIT_C), .INIT_VALID(INIT_V)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_pkt(cfg_wr_pkt), .cfg_wr_chan(cfg_wr_chan), .cfg_wr_valid(cfg_wr_valid),
    .cfg_wr_err(cfg_wr_err), .cfg_enq(cfg_enq), .cfg_pkt(cfg_pkt), .cfg_full(cfg_full),
    .busy(busy), .init_done(init_done), .sent_count(sent_count)
  );

  pe_autoconfig_seq #(
    .DEPTH(DEPTH), .CHANNELS(CHANNELS), .PKT_W(PKT_W), .GAP_CYCLES(0), .AUTO_START(1),
    .INIT_PKTS(INIT_P), .INIT_CHAN(INIT_C), .INIT_VALID(INIT_V)
  ) u_dut0 (
    .clk(clk), .rst(rst), .start(1'b0), .cfg_wr_en(1'b0), .cfg_wr_addr(3'd0),
    .cfg_wr_pkt(36'd0), .cfg_wr_chan(2'd0), .cfg_wr_valid(1'b0),
    .cfg_wr_err(cfg_wr_err0), .cfg_enq(cfg_enq0), .cfg_pkt(cfg_pkt0), .cfg_full(4'b0000),
    .busy(busy0), .init_done(init_done0), .sent_count(sent_count0)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic void chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endfunction

  function automatic logic [35:0] boot_pkt(input int i);
    return {4'hA, 8'(16 + i), 24'(24'h111111 * i)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_pkt[i]   = boot_pkt(i);
      m_chan[i]  = 2'd1;
      m_valid[i] = 1'b1;
    end
  endtask

  // Pushes the expected enqueue schedule for a run whose ISSUE of entry 0 is cycle `first`.
  task automatic model_run(input int first, input int sidx, input int slen, output int len, output int scyc);
    int t;
    t    = first;
    scyc = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[i]) begin
        if (i == sidx) begin
          scyc = t;
          t    = t + slen;
        end
        exp_q.push_back('{t, int'(m_chan[i]), m_pkt[i]});
        t = t + 1 + GAP;
      end else begin
        t = t + 1;
      end
    end
    len = t - first;
  endtask

  exp_t        mon_e;
  logic [VW-1:0] mon_v;
  always @(negedge clk) begin
    if (!rst && cfg_enq != '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_enq cyc=%0d actual=%b required=none", cyc, cfg_enq);
      end else begin
        mon_e = exp_q.pop_front();
        mon_v = '0;
        mon_v[mon_e.chan*PKT_W +: PKT_W] = mon_e.pkt;
        chk("enq_cycle", VW'(cyc), VW'(mon_e.cyc));
        chk("enq_lane", VW'(cfg_enq), VW'(1 << mon_e.chan));
        chk("enq_pkt", cfg_pkt, mon_v);
      end
    end
  end

  // Caller sits at posedge+1 of cycle `first`; walks the run to its expected completion.
  task automatic run_check(input int first, input int len, input int exp_sent, input int sc,
                           input int slo, input int shi, input int wcyc);
    for (int k = 0; k <= len; k++) begin
      cfg_full = '0;
      if (cyc >= slo && cyc < shi) cfg_full[sc] = 1'b1;
      cfg_wr_en    = (wcyc >= 0) && (cyc == wcyc);
      start        = (wcyc >= 0) && (cyc == wcyc);
      cfg_wr_addr  = 3'd4;
      cfg_wr_pkt   = 36'hFDEADBEEF;
      cfg_wr_chan  = 2'd3;
      cfg_wr_valid = 1'b1;
      @(negedge clk);
      if (k == 0) begin
        chk("run_cnt_clear", VW'(sent_count), VW'(0));
        chk("run_busy", VW'(busy), VW'(1));
      end
      if (k == len - 1) chk("pre_done", VW'(init_done), VW'(0));
      if (k == len) begin
        chk("done", VW'(init_done), VW'(1));
        chk("done_busy", VW'(busy), VW'(0));
        chk("sent_count", VW'(sent_count), VW'(exp_sent));
      end
      if (wcyc >= 0 && cyc == wcyc + 1) chk("wr_err_pulse", VW'(cfg_wr_err), VW'(1));
      if (wcyc >= 0 && cyc == wcyc + 2) chk("wr_err_clear", VW'(cfg_wr_err), VW'(0));
      @(posedge clk);
      #1;
    end
    cfg_full  = '0;
    cfg_wr_en = 1'b0;
    start     = 1'b0;
    chk("missing_enq", VW'(exp_q.size()), VW'(0));
  endtask

  initial begin
    @(negedge rst);
    @(negedge clk);
    for (int k = 1; k <= 7; k++) begin
      logic [VW-1:0] pv;
      @(negedge clk);
      pv = '0;
      if (k <= 5) pv[PKT_W +: PKT_W] = boot_pkt(k - 1);
      chk("gap0_enq", VW'(cfg_enq0), (k <= 5) ? VW'(4'b0010) : VW'(0));
      chk("gap0_pkt", cfg_pkt0, pv);
      chk("gap0_done", VW'(init_done0), VW'(k >= 6));
      if (k == 7) chk("gap0_sent", VW'(sent_count0), VW'(5));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int first, len, scyc;
    vecs[0] = '{3, 36'hABCDE0123, 2, 1'b1, 1, 5, 10};
    vecs[1] = '{1, 36'h0,         0, 1'b0, 2, 4, 9};
    vecs[2] = '{3, 36'h0,         0, 1'b0, 1, 3, 8};
    vecs[3] = '{0, 36'h0,         0, 1'b0, 0, 0, 0};
    vecs[4] = '{2, 36'h0,         0, 1'b0, 0, 0, 0};
    vecs[5] = '{4, 36'h0,         0, 1'b0, 1, 0, 5};
    vecs[6] = '{4, 36'h987654321, 3, 1'b1, 2, 1, 6};
    vecs[7] = '{0, 36'h100000001, 0, 1'b1, 1, 2, 7};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", VW'(busy), VW'(0));
    chk("rst_done", VW'(init_done), VW'(0));
    chk("rst_sent", VW'(sent_count), VW'(0));
    chk("rst_enq", VW'(cfg_enq), VW'(0));
    chk("rst_wr_err", VW'(cfg_wr_err), VW'(0));

    // Auto-start after reset, GAP=1: enq on cycles 1,3,5,7,9.
    model_run(1, -1, 0, len, scyc);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_check(1, 10, 5, 0, 0, 0, -1);

    // Restart with a 4-cycle full on entry 2, plus a write and start while busy.
    start = 1'b1;
    model_run(cyc + 1, 2, 4, len, scyc);
    @(posedge clk);
    #1;
    start = 1'b0;
    first = cyc;
    run_check(first, 14, 5, 1, scyc, scyc + 4, first + 1);

    // Reset while entry 2 is being enqueued.
    start = 1'b1;
    model_run(cyc + 1, 2, 0, len, scyc);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 0; n < 20 && cyc < scyc; n++) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_enq", VW'(cfg_enq), VW'(4'b0010));
    chk("pre_rst_sent", VW'(sent_count), VW'(2));
    rst = 1'b1;
    #1;
    chk("mid_rst_enq", VW'(cfg_enq), VW'(0));
    chk("mid_rst_busy", VW'(busy), VW'(0));
    chk("mid_rst_done", VW'(init_done), VW'(0));
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    model_run(1, -1, 0, len, scyc);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_check(1, 10, 5, 0, 0, 0, -1);

    // Table edits in DONE followed by reruns; mode 1 = write then start, mode 2 = same edge.
    for (int v = 0; v < 8; v++) begin
      cfg_wr_en    = 1'b1;
      cfg_wr_addr  = 3'(vecs[v].addr);
      cfg_wr_pkt   = vecs[v].pkt;
      cfg_wr_chan  = 2'(vecs[v].chan);
      cfg_wr_valid = vecs[v].valid;
      start        = (vecs[v].mode == 2);
      m_pkt[vecs[v].addr]   = vecs[v].pkt;
      m_chan[vecs[v].addr]  = 2'(vecs[v].chan);
      m_valid[vecs[v].addr] = vecs[v].valid;
      if (vecs[v].mode == 2) model_run(cyc + 1, -1, 0, len, scyc);
      @(posedge clk);
      #1;
      cfg_wr_en = 1'b0;
      start     = 1'b0;
      chk("idle_wr_no_err", VW'(cfg_wr_err), VW'(0));
      if (vecs[v].mode == 1) begin
        start = 1'b1;
        model_run(cyc + 1, -1, 0, len, scyc);
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      if (vecs[v].mode != 0) run_check(cyc, vecs[v].exp_len, vecs[v].exp_sent, 0, 0, 0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
